// File: rtl/divide_scheduler_if.sv
// Bundle between the voice engines, the divide_scheduler and its divide instance.
// The master view belongs to the environment; the slave view belongs to the scheduler.
interface divide_scheduler_if #(
  parameter int NUM_REQ = 4
) ();
  localparam int IDW = $clog2(NUM_REQ);

  logic                    enable;
  logic [NUM_REQ-1:0]      req;
  logic [16*NUM_REQ-1:0]   req_num;
  logic [16*NUM_REQ-1:0]   req_coef;
  logic [NUM_REQ-1:0]      gnt;
  logic [15:0]             div_numerator;
  logic [3:0]              div_a;
  logic [3:0]              div_b;
  logic [3:0]              div_c;
  logic [3:0]              div_d;
  logic [15:0]             div_dout;
  logic                    rsp_valid;
  logic [IDW-1:0]          rsp_id;
  logic [15:0]             rsp_data;
  logic                    busy;

  modport master (
    output enable, req, req_num, req_coef, div_dout,
    input  gnt, div_numerator, div_a, div_b, div_c, div_d,
    input  rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    input  enable, req, req_num, req_coef, div_dout,
    output gnt, div_numerator, div_a, div_b, div_c, div_d,
    output rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/divide_scheduler.sv
// Round-robin time-sharing of one divide scaler between NUM_REQ requesters; an ID
// tag pipeline follows each operation through divide and returns the tagged result.
module divide_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DIV_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  divide_scheduler_if.slave bus
);
  localparam int IDW    = $clog2(NUM_REQ);
  localparam int STAGES = DIV_LAT + 1;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int SH_W   = COEF_W / 4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                           r_state;
  logic                             r_busy;
  logic [IDW-1:0]                   r_ptr;
  logic [NUM_REQ-1:0]               r_gnt;
  logic signed [DATA_W-1:0]         r_div_num;
  logic [SH_W-1:0]                  r_div_a;
  logic [SH_W-1:0]                  r_div_b;
  logic [SH_W-1:0]                  r_div_c;
  logic [SH_W-1:0]                  r_div_d;
  logic [STAGES-1:0]                r_vld_p;
  logic [STAGES-1:0][IDW-1:0]       r_id_p;
  logic                             r_rsp_valid;
  logic [IDW-1:0]                   r_rsp_id;
  logic signed [DATA_W-1:0]         r_rsp_data;

  logic [IDW-1:0]                   w_idx      [NUM_REQ];
  logic [DATA_W-1:0]                w_num_arr  [NUM_REQ];
  logic [COEF_W-1:0]                w_coef_arr [NUM_REQ];
  logic                             w_hit;
  logic [IDW-1:0]                   w_win;
  logic [DATA_W-1:0]                w_sel_num;
  logic [COEF_W-1:0]                w_sel_coef;
  logic                             w_issue;
  logic                             w_empty;
  logic [NUM_REQ-1:0]               w_gnt_oh;

  function automatic logic [IDW-1:0] ring_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // w_idx[k] is the requester examined k-th when searching upward from the pointer.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign w_idx[g]      = ring_idx(r_ptr, g);
    assign w_num_arr[g]  = bus.req_num[DATA_W*g +: DATA_W];
    assign w_coef_arr[g] = bus.req_coef[COEF_W*g +: COEF_W];
  end

  always_comb begin
    w_hit      = 1'b0;
    w_win      = '0;
    w_sel_num  = '0;
    w_sel_coef = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_hit && bus.req[w_idx[k]]) begin
        w_hit      = 1'b1;
        w_win      = w_idx[k];
        w_sel_num  = w_num_arr[w_idx[k]];
        w_sel_coef = w_coef_arr[w_idx[k]];
      end
    end
  end

  assign w_issue  = (r_state == S_RUN) && bus.enable && w_hit;
  assign w_empty  = ~|r_vld_p;
  assign w_gnt_oh = NUM_REQ'(1) << w_win;

  // p0: issue edge; pN: tag N edges into divide; p(STAGES-1) lines up with div_dout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_div_num   <= '0;
      r_div_a     <= '0;
      r_div_b     <= '0;
      r_div_c     <= '0;
      r_div_d     <= '0;
      r_vld_p     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= bus.enable ? S_RUN : S_IDLE;
          r_busy  <= bus.enable;
        end
        S_RUN: begin
          r_state <= bus.enable ? S_RUN : S_DRAIN;
          r_busy  <= 1'b1;
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_state <= bus.enable ? S_RUN : S_IDLE;
            r_busy  <= bus.enable;
          end else begin
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      r_gnt <= w_issue ? w_gnt_oh : '0;
      if (w_issue) begin
        r_ptr     <= ring_idx(w_win, 1);
        r_div_num <= w_sel_num;
        r_div_a   <= w_sel_coef[4*SH_W-1:3*SH_W];
        r_div_b   <= w_sel_coef[3*SH_W-1:2*SH_W];
        r_div_c   <= w_sel_coef[2*SH_W-1:SH_W];
        r_div_d   <= w_sel_coef[SH_W-1:0];
      end

      r_vld_p     <= {r_vld_p[STAGES-2:0], w_issue};
      // Results are only taken when the tag says divide is holding one of ours.
      r_rsp_valid <= r_vld_p[STAGES-1];
      if (r_vld_p[STAGES-1]) begin
        r_rsp_id   <= r_id_p[STAGES-1];
        r_rsp_data <= bus.div_dout;
      end
    end
  end

  // Tag IDs are meaningful only alongside r_vld_p, so they carry no reset.
  always_ff @(posedge clk) begin
    r_id_p <= {r_id_p[STAGES-2:0], w_win};
  end

  assign bus.gnt           = r_gnt;
  assign bus.div_numerator = r_div_num;
  assign bus.div_a         = r_div_a;
  assign bus.div_b         = r_div_b;
  assign bus.div_c         = r_div_c;
  assign bus.div_d         = r_div_d;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_id        = r_rsp_id;
  assign bus.rsp_data      = r_rsp_data;
  assign bus.busy          = r_busy;
endmodule

// File: tb/tb_divide_scheduler.sv
// Bench for divide_scheduler: directed vectors and sequences plus a randomized run
// scored against a queue-based model; a behavioural divide stub closes the loop.
module tb_divide_scheduler;
  localparam int NR  = 4;
  localparam int LAT = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  divide_scheduler_if #(.NUM_REQ(NR)) bus ();

  divide_scheduler #(.NUM_REQ(NR), .DIV_LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Sum of arithmetic right shifts of num by each of a,b,c,d; codes 0 and 15 disable a term.
  function automatic logic [15:0] div_ref(input logic [15:0] num, input logic [15:0] coef);
    int acc;
    int n;
    logic [3:0] c4;
    acc = 0;
    n = int'(signed'(num));
    for (int k = 0; k < 4; k++) begin
      c4 = coef[15-4*k -: 4];
      if (c4 != 4'd0 && c4 != 4'd15) acc += (n >>> c4);
    end
    return 16'(acc);
  endfunction

  // divide stand-in: LAT register stages, no connection to the scheduler reset
  logic [15:0] stub_p1 = '0;
  logic [15:0] stub_p2 = '0;
  always_ff @(posedge clk) begin
    stub_p1 <= div_ref(bus.div_numerator, {bus.div_a, bus.div_b, bus.div_c, bus.div_d});
    stub_p2 <= stub_p1;
  end
  assign bus.div_dout = stub_p2;

  typedef struct {
    int          id;
    logic [15:0] data;
    int          due;
  } exp_t;

  typedef struct {
    int          id;
    logic [15:0] num;
    logic [15:0] coef;
    logic [15:0] exp_data;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          m_state;
  int          m_ptr;
  logic [15:0] m_div_num;
  logic [15:0] m_div_coef;
  logic [15:0] m_rsp_data;
  int          m_rsp_id;
  bit          m_gnt_v;
  int          m_gnt_id;
  exp_t        exp_q[$];
  int          got_ids[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] num, input logic [15:0] coef);
    bus.req_num[16*i +: 16]  = num;
    bus.req_coef[16*i +: 16] = coef;
  endtask

  task automatic model_reset();
    m_state    = M_IDLE;
    m_ptr      = 0;
    m_div_num  = '0;
    m_div_coef = '0;
    m_rsp_data = '0;
    m_rsp_id   = 0;
    m_gnt_v    = 1'b0;
    m_gnt_id   = 0;
    exp_q.delete();
  endtask

  // One clock: predict from the inputs presented, advance, then score the outputs.
  task automatic step();
    bit          en;
    logic [NR-1:0] rq;
    logic [16*NR-1:0] nums, coefs;
    bit          empty;
    bit          win_v;
    int          win;
    int          nxt;
    int          i;
    exp_t        e;
    en    = bus.enable;
    rq    = bus.req;
    nums  = bus.req_num;
    coefs = bus.req_coef;
    empty = (exp_q.size() == 0);
    win_v = 1'b0;
    win   = 0;
    if (m_state == M_RUN && en) begin
      for (int k = 0; k < NR; k++) begin
        i = (m_ptr + k) % NR;
        if (!win_v && rq[i]) begin
          win_v = 1'b1;
          win   = i;
        end
      end
    end
    nxt = m_state;
    case (m_state)
      M_IDLE:  if (en) nxt = M_RUN;
      M_RUN:   if (!en) nxt = M_DRAIN;
      default: if (empty) nxt = en ? M_RUN : M_IDLE;
    endcase

    @(posedge clk);
    #1;
    cyc++;

    if (win_v) begin
      chk("gnt", 32'(bus.gnt), 32'(1) << win);
      e.id   = win;
      e.data = div_ref(nums[16*win +: 16], coefs[16*win +: 16]);
      e.due  = cyc + LAT + 1;
      exp_q.push_back(e);
      m_ptr      = (win + 1) % NR;
      m_div_num  = nums[16*win +: 16];
      m_div_coef = coefs[16*win +: 16];
    end else begin
      chk("gnt_none", 32'(bus.gnt), 0);
    end
    chk("div_num", 32'(bus.div_numerator), 32'(m_div_num));
    chk("div_coef", 32'({bus.div_a, bus.div_b, bus.div_c, bus.div_d}), 32'(m_div_coef));

    if (bus.rsp_valid === 1'b1) got_ids.push_back(int'(bus.rsp_id));
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk("rsp_valid", 32'(bus.rsp_valid), 1);
      chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
      chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
      m_rsp_id   = e.id;
      m_rsp_data = e.data;
    end else begin
      chk("rsp_quiet", 32'(bus.rsp_valid), 0);
      chk("rsp_hold", 32'({bus.rsp_id, bus.rsp_data}), 32'({2'(m_rsp_id), m_rsp_data}));
    end

    m_state = nxt;
    chk("busy", 32'(bus.busy), (nxt != M_IDLE) ? 1 : 0);
    m_gnt_v  = win_v;
    m_gnt_id = win;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 0);
    chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 0);
    chk({tag, "_div"}, 32'({bus.div_numerator, bus.div_a, bus.div_b, bus.div_c, bus.div_d}), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  vec_t vecs[5];
  int   cont_seq[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    vecs[0] = '{id: 1, num: 16'h03E8, coef: 16'h1200, exp_data: 16'd750};
    vecs[1] = '{id: 1, num: 16'hFC18, coef: 16'h1200, exp_data: 16'hFD12};
    vecs[2] = '{id: 3, num: 16'h1000, coef: 16'h4F00, exp_data: 16'h0100};
    vecs[3] = '{id: 0, num: 16'h7FFF, coef: 16'h1111, exp_data: 16'hFFFC};
    vecs[4] = '{id: 2, num: 16'h8000, coef: 16'h3000, exp_data: 16'hF000};

    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.req      = '0;
    bus.req_num  = '0;
    bus.req_coef = '0;
    model_reset();
    #2;
    do_reset("rst");

    bus.enable = 1'b1;
    step();

    // Contention from ptr=0: all four held high.
    for (int i = 0; i < NR; i++) set_op(i, 16'(1000 * (i + 1)), 16'h1200 + 16'(i));
    got_ids.delete();
    bus.req = 4'hF;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("cont_gnt", 32'(bus.gnt), 32'(1) << cont_seq[k]);
    end
    bus.req = '0;
    repeat (4) step();
    chk("cont_rsp_count", 32'(got_ids.size()), 6);
    for (int k = 0; k < 6 && k < got_ids.size(); k++) chk("cont_rsp_order", 32'(got_ids[k]), 32'(cont_seq[k]));

    // Fairness: pointer now sits at 2.
    set_op(2, 16'h0400, 16'h2000);
    bus.req = 4'b0100;
    step();
    chk("fair_first", 32'(bus.gnt), 32'h4);
    set_op(0, 16'h0200, 16'h1000);
    bus.req[0] = 1'b1;
    step();
    chk("fair_second", 32'(bus.gnt), 32'h1);
    bus.req[0] = 1'b0;
    step();
    chk("fair_third", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    repeat (4) step();

    // Single-request vectors.
    for (int v = 0; v < 5; v++) begin
      set_op(vecs[v].id, vecs[v].num, vecs[v].coef);
      bus.req = 4'(1 << vecs[v].id);
      step();
      chk("vec_gnt", 32'(bus.gnt), 32'(1) << vecs[v].id);
      bus.req = '0;
      repeat (3) step();
      chk("vec_rsp_valid", 32'(bus.rsp_valid), 1);
      chk("vec_rsp_id", 32'(bus.rsp_id), 32'(vecs[v].id));
      chk("vec_rsp_data", 32'(bus.rsp_data), 32'(vecs[v].exp_data));
      step();
    end

    // Drain: two issues, then enable drops while req[1] stays up.
    set_op(1, 16'h0100, 16'h1000);
    bus.req = 4'b0010;
    step();
    set_op(1, 16'h0200, 16'h2000);
    step();
    chk("drain_gnt2", 32'(bus.gnt), 32'h2);
    bus.enable = 1'b0;
    for (int s = 1; s <= 6; s++) begin
      step();
      chk("drain_no_gnt", 32'(bus.gnt), 0);
      chk("drain_busy", 32'(bus.busy), (s <= 3) ? 1 : 0);
      if (s == 2 || s == 3) chk("drain_rsp", 32'(bus.rsp_valid), 1);
    end
    bus.req = '0;

    // Reset one cycle after a grant.
    bus.enable = 1'b1;
    step();
    set_op(3, 16'h1234, 16'h1200);
    bus.req = 4'b1000;
    step();
    chk("mid_gnt", 32'(bus.gnt), 32'h8);
    bus.req = '0;
    step();
    do_reset("mid");
    for (int s = 0; s < 6; s++) begin
      step();
      chk("mid_no_rsp", 32'(bus.rsp_valid), 0);
    end

    // Randomized traffic with enable toggling.
    for (int t = 0; t < 2500; t++) begin
      step();
      for (int i = 0; i < NR; i++) begin
        if (m_gnt_v && m_gnt_id == i) begin
          if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
          else set_op(i, 16'($urandom), 16'($urandom));
        end else if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
          set_op(i, 16'($urandom), 16'($urandom));
          bus.req[i] = 1'b1;
        end
      end
      if ($urandom_range(0, 39) == 0) bus.enable = ~bus.enable;
    end
    bus.enable = 1'b0;
    bus.req    = '0;
    repeat (12) step();
    chk("final_idle", 32'(bus.busy), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/divide_scheduler.md
Name: divide_scheduler

Overview:
- Round-robin arbiter that time-shares one `divide` shift-add scaler between NUM_REQ requesters (voice gain stages).
- Registers the granted requester's numerator and {a,b,c,d} shift codes onto the divide inputs.
- Tracks the request ID through the divide pipeline and returns each result, tagged with its ID, as a one-cycle response.
- Sits between the voice engines and a single `divide` instance in the mixer path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); ID width is IDW = clog2(NUM_REQ).
- DIV_LAT, 2, register stages inside `divide` between its inputs and `dout`.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = grant new requests; 0 = stop granting and drain.
- req  in  NUM_REQ  per-requester request level.
- req_num  in  16*NUM_REQ  numerator for requester i, in bits [16i+15:16i].
- req_coef  in  16*NUM_REQ  {a,b,c,d} for requester i, a in MSBs.
- gnt  out  NUM_REQ  one-hot, one-cycle grant pulse.
- div_numerator  out  16  to divide.numerator.
- div_a, div_b, div_c, div_d  out  4 each  to divide a/b/c/d.
- div_dout  in  16  from divide.dout.
- rsp_valid  out  1  result strobe.
- rsp_id  out  IDW  requester index of the result.
- rsp_data  out  16  scaled result.
- busy  out  1  high in RUN or DRAIN.

Behaviour:
- Reset (async assert, sync release):
  - gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, div_* =0, busy=0.
  - Tag pipeline valids cleared; round-robin pointer = 0; state = IDLE.
- States:
  - IDLE: no grants. enable=1 -> RUN.
  - RUN: grants issued. enable=0 -> DRAIN.
  - DRAIN: no grants; waits until no tag is valid. Empty and enable=0 -> IDLE; empty and enable=1 -> RUN.
  - enable re-asserted mid-DRAIN: the block finishes draining first.
- Arbitration (RUN, evaluated each cycle):
  - Winner = first i with req[i]=1, searching from ptr upward modulo NUM_REQ.
  - At the clock edge: gnt[winner]=1 for exactly one cycle; div_numerator/div_a..d <= that requester's fields; ptr <= winner+1 mod NUM_REQ.
  - No req -> gnt=0, div_* hold their last value, ptr unchanged.
- Issue rate: at most one grant per cycle; back-to-back grants are allowed.
- Requester obligations:
  - Hold req_num/req_coef stable while req=1.
  - On a gnt pulse, either drop req or present the next operand in the following cycle.
  - A requester whose req stays high is re-granted only after every other asserting requester has been served.
- Tag pipeline:
  - Issue edge E loads {valid=1, id=winner} into a shift register of DIV_LAT+1 stages.
  - The final stage aligns with div_dout being valid after edge E+DIV_LAT.
  - At edge E+DIV_LAT+1: rsp_data <= div_dout, rsp_id <= tag id, rsp_valid <= 1.
  - Issue-to-rsp_valid is DIV_LAT+1 cycles after the gnt cycle; responses return in issue order.
- Non-issue cycles:
  - Shift in valid=0; rsp_valid=0; rsp_data/rsp_id hold their last value.
  - div_dout is ignored when the tag stage is invalid. This covers garbage after reset, since divide's own reset is separate.
- Responses have no backpressure; consumers must accept rsp_valid every cycle.
- Arithmetic: none in this block. Operands pass through unchanged; sign handling and the zero/15 term-disable codes belong to divide.
- busy = (state != IDLE), registered.
- Reset asserted mid-flight: in-flight tags are lost and no rsp_valid is produced for them.

Test Plan:
- Single request: req[1]=1, num=1000 (0x03E8), coef a=1,b=2,c=0,d=0. Expect gnt[1] for 1 cycle, then rsp_valid 3 cycles later with rsp_id=1, rsp_data=750.
- Negative operand: num=0xFC18 (-1000), same coef. Expect rsp_data=0xFD12 (-750).
- Contention: all four req high and held, ptr=0. Expect grants 0,1,2,3,0,1 on consecutive cycles and responses in the same order, 3 cycles behind each grant.
- Fairness: req[2] held high; req[0] pulses high once after the grant to 2. Expect the next grant to go to 0, then 2.
- Drain: issue 2 ops, then drop enable in the next cycle. Expect no further gnt; busy stays high until both responses appear, then busy=0 one cycle later.
- Reset mid-flight: assert reset one cycle after a grant. Expect all outputs 0 immediately and no rsp_valid after release, even though divide outputs are nonzero.
